// File: rtl/rf_pkg.sv
// Shared widths, requester indices and the write-request record for the
// register-file write arbiter.
package rf_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_LD  = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] wreg;
    logic [DATA_W-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on
// commit, wiped on flush; decode reads it through the hazard lookup.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = rf_pkg::ADDR_W,
  parameter int NUM_REGS = rf_pkg::NUM_REGS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_reg,
  input  logic                flush,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_reg,
  input  logic [ADDR_W-1:0]   chk_reg1,
  input  logic [ADDR_W-1:0]   chk_reg2,
  output logic                hazard,
  output logic [NUM_REGS-1:0] pend_mask
);

  logic [NUM_REGS-1:0] pend_next;

  // Next-state per register: flush beats everything, then a fresh issue beats a commit.
  always_comb begin
    pend_next = pend_mask;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (flush) begin
        pend_next[r] = 1'b0;
      end else if (issue_valid && (issue_reg == ADDR_W'(r))) begin
        pend_next[r] = 1'b1;
      end else if (wr_en && (wr_reg == ADDR_W'(r))) begin
        pend_next[r] = 1'b0;
      end else begin
        pend_next[r] = pend_mask[r];
      end
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_mask <= {NUM_REGS{1'b0}};
    end else begin
      pend_mask <= pend_next;
    end
  end

  assign hazard = pend_mask[chk_reg1] | pend_mask[chk_reg2];

endmodule

// File: rtl/rf_write_arbiter.sv
// Two-requester arbiter for the register-file write port with a registered
// write stage and pending-write scoreboard. Build option: RF_WARB_ROUND_ROBIN_EN.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W   = rf_pkg::DATA_W,
  parameter int ADDR_W   = rf_pkg::ADDR_W,
  parameter int NUM_REGS = rf_pkg::NUM_REGS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [ADDR_W-1:0]   req0_reg,
  input  logic [DATA_W-1:0]   req0_data,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [ADDR_W-1:0]   req1_reg,
  input  logic [DATA_W-1:0]   req1_data,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_reg,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   chk_reg1,
  input  logic [ADDR_W-1:0]   chk_reg2,
  output logic                hazard,
  output logic [NUM_REGS-1:0] pend_mask,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_wreg,
  output logic [DATA_W-1:0]   rf_wdata
);

  logic   xfer;
  rf_wr_t sel;

`ifdef RF_WARB_ROUND_ROBIN_EN
  logic rr_ptr;

  // Round-robin grant: preferred requester wins a collision.
  always_comb begin
    if (req0_valid && req1_valid) begin
      req0_ready = (rr_ptr == REQ_ALU);
      req1_ready = (rr_ptr == REQ_LD);
    end else begin
      req0_ready = req0_valid;
      req1_ready = req1_valid;
    end
  end

  // Pointer only rotates when both requesters competed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= REQ_ALU;
    end else if (req0_valid && req1_valid) begin
      rr_ptr <= ~rr_ptr;
    end else begin
      rr_ptr <= rr_ptr;
    end
  end
`else
  // Fixed priority grant: ALU writeback always wins.
  always_comb begin
    req0_ready = req0_valid;
    req1_ready = req1_valid & ~req0_valid;
  end
`endif

  // Mux the granted request into the write record.
  always_comb begin
    if (req0_ready) begin
      sel = '{wreg: req0_reg, data: req0_data};
    end else begin
      sel = '{wreg: req1_reg, data: req1_data};
    end
  end

  assign xfer = req0_ready | req1_ready;

  // Registered write stage; reset drops any accepted-but-uncommitted write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_wreg  <= {ADDR_W{1'b0}};
      rf_wdata <= {DATA_W{1'b0}};
    end else if (xfer) begin
      rf_we    <= 1'b1;
      rf_wreg  <= sel.wreg;
      rf_wdata <= sel.data;
    end else begin
      rf_we    <= 1'b0;
      rf_wreg  <= rf_wreg;
      rf_wdata <= rf_wdata;
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_reg   (issue_reg),
    .flush       (flush),
    .wr_en       (rf_we),
    .wr_reg      (rf_wreg),
    .chk_reg1    (chk_reg1),
    .chk_reg2    (chk_reg2),
    .hazard      (hazard),
    .pend_mask   (pend_mask)
  );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter (either grant configuration).
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [3:0]  req0_reg;
  logic [15:0] req0_data;
  logic        req1_valid, req1_ready;
  logic [3:0]  req1_reg;
  logic [15:0] req1_data;
  logic        issue_valid;
  logic [3:0]  issue_reg;
  logic        flush;
  logic [3:0]  chk_reg1, chk_reg2;
  logic        hazard;
  logic [15:0] pend_mask;
  logic        rf_we;
  logic [3:0]  rf_wreg;
  logic [15:0] rf_wdata;

  int total = 0;
  int fails = 0;
  int g0, g1;
  logic [3:0] order;
  logic [3:0] exp_order;
  int exp_g0, exp_g1;

  rf_write_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_reg(req0_reg), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_reg(req1_reg), .req1_data(req1_data),
    .issue_valid(issue_valid), .issue_reg(issue_reg), .flush(flush),
    .chk_reg1(chk_reg1), .chk_reg2(chk_reg2), .hazard(hazard), .pend_mask(pend_mask),
    .rf_we(rf_we), .rf_wreg(rf_wreg), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_reg = 4'd0; req0_data = 16'h0000;
    req1_valid = 1'b0; req1_reg = 4'd0; req1_data = 16'h0000;
    issue_valid = 1'b0; issue_reg = 4'd0; flush = 1'b0;
    chk_reg1 = 4'd0; chk_reg2 = 4'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    // 1: reset then idle
    chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
    chk("reset_pend", {16'd0, pend_mask}, 32'h0000);
    chk("reset_hazard", {31'd0, hazard}, 32'd0);
    chk("reset_ready0", {31'd0, req0_ready}, 32'd0);
    chk("reset_ready1", {31'd0, req1_ready}, 32'd0);

    // 2: req0 alone
    req0_valid = 1'b1; req0_reg = 4'd3; req0_data = 16'hBEEF;
    #1;
    chk("t2_ready0", {31'd0, req0_ready}, 32'd1);
    chk("t2_ready1", {31'd0, req1_ready}, 32'd0);
    step();
    req0_valid = 1'b0;
    chk("t2_we", {31'd0, rf_we}, 32'd1);
    chk("t2_wreg", {28'd0, rf_wreg}, 32'd3);
    chk("t2_wdata", {16'd0, rf_wdata}, 32'h0000BEEF);
    step();
    chk("t2_we_idle", {31'd0, rf_we}, 32'd0);

    // 3: both valid for four cycles
    req0_valid = 1'b1; req0_reg = 4'd1; req0_data = 16'h1111;
    req1_valid = 1'b1; req1_reg = 4'd2; req1_data = 16'h2222;
    g0 = 0; g1 = 0; order = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (req0_ready) g0++;
      if (req1_ready) begin
        g1++;
        order[i] = 1'b1;
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
`ifdef RF_WARB_ROUND_ROBIN_EN
    exp_g0 = 2; exp_g1 = 2; exp_order = 4'b1010;
`else
    exp_g0 = 4; exp_g1 = 0; exp_order = 4'b0000;
`endif
    chk("t3_grants0", g0, exp_g0);
    chk("t3_grants1", g1, exp_g1);
    chk("t3_order", {28'd0, order}, {28'd0, exp_order});
    chk("t3_last_we", {31'd0, rf_we}, 32'd1);
    chk("t3_last_wdata", {16'd0, rf_wdata}, exp_order[3] ? 32'h00002222 : 32'h00001111);
    step();

    // 4: hazard lifetime for r5
    issue_valid = 1'b1; issue_reg = 4'd5;
    step();
    issue_valid = 1'b0; chk_reg1 = 4'd5; chk_reg2 = 4'd0;
    #1;
    chk("t4_pend", {16'd0, pend_mask}, 32'h00000020);
    chk("t4_hazard_src1", {31'd0, hazard}, 32'd1);
    chk_reg1 = 4'd0; chk_reg2 = 4'd5;
    #1;
    chk("t4_hazard_src2", {31'd0, hazard}, 32'd1);
    chk_reg2 = 4'd6;
    #1;
    chk("t4_no_hazard_other", {31'd0, hazard}, 32'd0);
    chk_reg1 = 4'd5;
    req1_valid = 1'b1; req1_reg = 4'd5; req1_data = 16'h5555;
    #1;
    chk("t4_ready1_alone", {31'd0, req1_ready}, 32'd1);
    step();
    req1_valid = 1'b0;
    chk("t4_commit_we", {31'd0, rf_we}, 32'd1);
    chk("t4_commit_wreg", {28'd0, rf_wreg}, 32'd5);
    chk("t4_hazard_during_commit", {31'd0, hazard}, 32'd1);
    step();
    chk("t4_hazard_after", {31'd0, hazard}, 32'd0);
    chk("t4_pend_after", {16'd0, pend_mask}, 32'h0000);

    // 5: issue and commit to r7 on the same edge
    req0_valid = 1'b1; req0_reg = 4'd7; req0_data = 16'h7777;
    step();
    req0_valid = 1'b0;
    issue_valid = 1'b1; issue_reg = 4'd7;
    chk("t5_we", {31'd0, rf_we}, 32'd1);
    step();
    issue_valid = 1'b0;
    chk("t5_pend_set_wins", {16'd0, pend_mask}, 32'h00000080);

    // 6: flush overrides a simultaneous issue
    for (int r = 4; r < 7; r++) begin
      issue_valid = 1'b1; issue_reg = 4'(r);
      step();
    end
    issue_valid = 1'b0;
    chk("t6_pend_pre", {16'd0, pend_mask}, 32'h000000F0);
    flush = 1'b1; issue_valid = 1'b1; issue_reg = 4'd2;
    step();
    flush = 1'b0; issue_valid = 1'b0;
    chk("t6_pend_flushed", {16'd0, pend_mask}, 32'h0000);

    // 6b: async reset drops a pending write
    req0_valid = 1'b1; req0_reg = 4'd9; req0_data = 16'h9999;
    step();
    req0_valid = 1'b0;
    chk("t6_we_before_rst", {31'd0, rf_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_we_async_rst", {31'd0, rf_we}, 32'd0);
    chk("t6_wdata_async_rst", {16'd0, rf_wdata}, 32'h0000);
    #1 rst = 1'b0;
    step();
    chk("t6_we_after_rst", {31'd0, rf_we}, 32'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
